// File: rtl/sccb_pkg.sv
// Shared SCCB target types: FSM state encoding, default device ID, bits per phase.
package sccb_pkg;
  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 4'd0,
    ST_ID        = 4'd1,
    ST_ID_X      = 4'd2,
    ST_SUB       = 4'd3,
    ST_SUB_X     = 4'd4,
    ST_WDAT      = 4'd5,
    ST_WDAT_X    = 4'd6,
    ST_RDAT      = 4'd7,
    ST_RD_NA     = 4'd8,
    ST_WAIT_STOP = 4'd9
  } state_t;

  localparam logic [7:0] ID_W_DEFAULT   = 8'h60;
  localparam logic [3:0] BITS_PER_PHASE = 4'd9;
endpackage

// File: rtl/sccb_line_sync.sv
// Synchronises sio_c/sio_d and emits one-clk scl_r, scl_f, start, stop pulses.
// Latency SYNC_STAGES+1 clk from pin change to pulse; no backpressure.
module sccb_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sio_c,
  input  logic sio_d_i,
  output logic sda,
  output logic scl_r,
  output logic scl_f,
  output logic start,
  output logic stop
);
  logic [SYNC_STAGES-1:0] c_sync;
  logic [SYNC_STAGES-1:0] d_sync;
  logic c_now, d_now, c_prev, d_prev;

  assign c_now = c_sync[SYNC_STAGES-1];
  assign d_now = d_sync[SYNC_STAGES-1];
  // d_prev lines up with the registered pulses, so it is the bit value seen at scl_r
  assign sda = d_prev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      c_sync <= '1;
      d_sync <= '1;
      c_prev <= 1'b1;
      d_prev <= 1'b1;
      scl_r  <= 1'b0;
      scl_f  <= 1'b0;
      start  <= 1'b0;
      stop   <= 1'b0;
    end else begin
      c_sync <= {c_sync[SYNC_STAGES-2:0], sio_c};
      d_sync <= {d_sync[SYNC_STAGES-2:0], sio_d_i};
      c_prev <= c_now;
      d_prev <= d_now;
      scl_r  <= c_now & ~c_prev;
      scl_f  <= ~c_now & c_prev;
      start  <= c_now & c_prev & d_prev & ~d_now;
      stop   <= c_now & c_prev & ~d_prev & d_now;
    end
  end
endmodule

// File: rtl/ov2640_sccb_target.sv
// SCCB target with a 256x8 register file; bits sampled on SCL rise, sio_d_oe moves on SCL fall.
// No backpressure. Define SCCB_TARGET_ACK_EN to drive I2C-style ACKs on the 9th bits.
module ov2640_sccb_target
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEV_ID      = ID_W_DEFAULT,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sio_c,
  input  logic       sio_d_i,
  output logic       sio_d_oe,
  output logic       wr_stb,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [7:0] cfg_addr,
  output logic [7:0] cfg_data,
  output logic       busy,
  output logic       id_err
);
`ifdef SCCB_TARGET_ACK_EN
  localparam logic ACK_EN = 1'b1;
`else
  localparam logic ACK_EN = 1'b0;
`endif

  logic       sda, scl_r, scl_f, start, stop;
  state_t     state;
  logic [3:0] cnt;
  logic [7:0] sh;
  logic [7:0] ptr;
  logic       rd;
  logic [7:0] byte_nxt;
  logic [7:0] regfile [256];

  sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .sio_c   (sio_c),
    .sio_d_i (sio_d_i),
    .sda     (sda),
    .scl_r   (scl_r),
    .scl_f   (scl_f),
    .start   (start),
    .stop    (stop)
  );

  assign byte_nxt = {sh[6:0], sda};
  assign cfg_data = regfile[cfg_addr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      sh       <= 8'h00;
      ptr      <= 8'h00;
      rd       <= 1'b0;
      sio_d_oe <= 1'b0;
      wr_stb   <= 1'b0;
      wr_addr  <= 8'h00;
      wr_data  <= 8'h00;
      busy     <= 1'b0;
      id_err   <= 1'b0;
      for (int i = 0; i < 256; i++) regfile[i] <= 8'h00;
    end else begin
      wr_stb <= 1'b0;
      if (stop) begin
        state    <= ST_IDLE;
        sio_d_oe <= 1'b0;
        busy     <= 1'b0;
      end else if (start) begin
        state    <= ST_ID;
        cnt      <= 4'd0;
        sio_d_oe <= 1'b0;
        busy     <= 1'b1;
      end else if (scl_r) begin
        case (state)
          ST_ID, ST_SUB, ST_WDAT: begin
            sh  <= byte_nxt;
            cnt <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              if (state == ST_ID) begin
                if (byte_nxt[7:1] == DEV_ID[7:1]) begin
                  rd    <= byte_nxt[0];
                  state <= ST_ID_X;
                end else begin
                  id_err <= 1'b1;
                  state  <= ST_WAIT_STOP;
                end
              end else if (state == ST_SUB) begin
                ptr   <= byte_nxt;
                state <= ST_SUB_X;
              end else begin
                regfile[ptr] <= byte_nxt;
                wr_stb       <= 1'b1;
                wr_addr      <= ptr;
                wr_data      <= byte_nxt;
                state        <= ST_WDAT_X;
              end
            end
          end
          ST_ID_X, ST_SUB_X, ST_WDAT_X: cnt <= cnt + 4'd1;
          ST_RDAT: begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'd7) state <= ST_RD_NA;
          end
          ST_RD_NA: state <= ST_WAIT_STOP;
          default: ;
        endcase
      end else if (scl_f) begin
        case (state)
          ST_ID_X, ST_SUB_X, ST_WDAT_X: begin
            // First fall after bit 8 opens the ACK slot; the fall after bit 9 leaves it
            if (cnt == BITS_PER_PHASE) begin
              cnt      <= 4'd0;
              sio_d_oe <= 1'b0;
              if (state == ST_ID_X && rd) begin
                state    <= ST_RDAT;
                sh       <= regfile[ptr];
                sio_d_oe <= ~regfile[ptr][7];
              end else if (state == ST_ID_X) begin
                state <= ST_SUB;
              end else if (state == ST_SUB_X) begin
                state <= ST_WDAT;
              end else begin
                state <= ST_WAIT_STOP;
              end
            end else begin
              sio_d_oe <= ACK_EN;
            end
          end
          ST_RDAT: begin
            sio_d_oe <= ~sh[6];
            sh       <= {sh[6:0], 1'b0};
          end
          default: sio_d_oe <= 1'b0;
        endcase
      end
    end
  end
endmodule
